// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Multiply-class ops complete after MUL_LAT cycles, divides after DIV_LAT
// cycles. MTHI/MTLO write HI/LO in a single cycle without raising busy.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (accumulate into {hi,lo}); when undefined those opcodes act as NOPs.
module mul_div_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = ($clog2(MAX_LAT + 1) > 4) ? $clog2(MAX_LAT + 1) : 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   lat_s;
    logic [3:0]         op_r;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic               busy_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;

    logic               launch_s;
    logic               mthi_s;
    logic               mtlo_s;
    logic               done_s;

    logic               mul_signed_s;
    logic               div_signed_s;
    logic [63:0]        a_ext_s;
    logic [63:0]        b_ext_s;
    logic [63:0]        prod_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [31:0]        a_mag_s;
    logic [31:0]        b_mag_s;
    logic [31:0]        quo_mag_s;
    logic [31:0]        rem_mag_s;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [63:0]        new_hilo_s;

    // Decode the incoming request; only honoured while idle.
    always_comb begin
        launch_s = 1'b0;
        mthi_s   = 1'b0;
        mtlo_s   = 1'b0;
        lat_s    = CNT_W'(MUL_LAT);
        if (start && (state_r == IDLE)) begin
            case (op)
                OP_MULT, OP_MULTU: launch_s = 1'b1;
                OP_DIV, OP_DIVU: begin
                    launch_s = 1'b1;
                    lat_s    = CNT_W'(DIV_LAT);
                end
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: launch_s = 1'b1;
`endif
                OP_MTHI: mthi_s = 1'b1;
                OP_MTLO: mtlo_s = 1'b1;
                default: launch_s = 1'b0;
            endcase
        end else begin
            launch_s = 1'b0;
        end
    end

    assign done_s = (state_r == RUN) && (cnt_r == CNT_W'(1));

    // Product from latched operands; sign-extending to 64 bits makes the
    // low 64 bits of an unsigned multiply equal the signed product.
    always_comb begin
        mul_signed_s = (op_r == OP_MULT);
`ifdef MDU_MADD_EN
        if ((op_r == OP_MADD) || (op_r == OP_MSUB)) begin
            mul_signed_s = 1'b1;
        end else begin
            mul_signed_s = (op_r == OP_MULT);
        end
`endif
        a_ext_s = mul_signed_s ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
        b_ext_s = mul_signed_s ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. 0x80000000 / -1 falls out as
    // 0x80000000 with remainder 0.
    always_comb begin
        div_signed_s = (op_r == OP_DIV);
        a_neg_s      = div_signed_s & a_r[31];
        b_neg_s      = div_signed_s & b_r[31];
        a_mag_s      = a_neg_s ? (32'd0 - a_r) : a_r;
        b_mag_s      = b_neg_s ? (32'd0 - b_r) : b_r;
        if (b_mag_s != 32'd0) begin
            quo_mag_s = a_mag_s / b_mag_s;
            rem_mag_s = a_mag_s % b_mag_s;
        end else begin
            quo_mag_s = 32'd0;
            rem_mag_s = 32'd0;
        end
        quo_s = (a_neg_s ^ b_neg_s) ? (32'd0 - quo_mag_s) : quo_mag_s;
        rem_s = a_neg_s ? (32'd0 - rem_mag_s) : rem_mag_s;
    end

    // Select the HI/LO value written at completion; divide by zero keeps it.
    always_comb begin
        new_hilo_s = {hi_r, lo_r};
        case (op_r)
            OP_MULT, OP_MULTU: new_hilo_s = prod_s;
            OP_DIV, OP_DIVU: begin
                if (b_r != 32'd0) begin
                    new_hilo_s = {rem_s, quo_s};
                end else begin
                    new_hilo_s = {hi_r, lo_r};
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: new_hilo_s = {hi_r, lo_r} + prod_s;
            OP_MSUB, OP_MSUBU: new_hilo_s = {hi_r, lo_r} - prod_s;
`endif
            default: new_hilo_s = {hi_r, lo_r};
        endcase
    end

    // Next-state logic: launch moves to RUN, final count returns to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (done_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath: operand latch, latency counter, busy flag and HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            op_r   <= 4'd0;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            busy_r <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
        end else if (state_r == IDLE) begin
            if (launch_s) begin
                op_r   <= op;
                a_r    <= a;
                b_r    <= b;
                cnt_r  <= lat_s;
                busy_r <= 1'b1;
            end else if (mthi_s) begin
                hi_r <= a;
            end else if (mtlo_s) begin
                lo_r <= a;
            end
        end else begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (done_s) begin
                hi_r   <= new_hilo_s[63:32];
                lo_r   <= new_hilo_s[31:0];
                busy_r <= 1'b0;
            end
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (MUL_LAT=5, DIV_LAT=10).
module tb_mul_div_unit;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd9;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for one edge, then scramble the operands.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NOP; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
    endtask

    // Count edges until busy falls, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int n);
        issue(o, x, y);
        wait_idle(n);
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    endtask

    task automatic test_mult;
        int n;
        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_lat got=%0d exp=5", n); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL multu_lat got=%0d exp=5", n); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got=%h exp=1", lo); end
    endtask

    task automatic test_div;
        int n;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL div_lat got=%0d exp=10", n); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, n);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, n);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdiv_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negdiv_hi got=%h exp=1", hi); end
        run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divu_lat got=%0d exp=10", n); end
        checks++; if (lo !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_lo got=%h exp=7ffffffc", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got=%h exp=1", hi); end
    endtask

    task automatic test_mtlo;
        issue(OP_MTLO, 32'h1234, 32'd0);
        checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo got=%h exp=1234", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL mtlo_hi got=%h exp=1", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mthi_during_div;
        int n;
        issue(OP_DIV, 32'd100, 32'd7);
        issue(OP_MTHI, 32'hDEAD, 32'd0);
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL mthi_busy_hi got=%h exp=1", hi); end
        wait_idle(n);
        checks++; if (n + 1 !== 9 + 1) begin errors++; $display("FAIL mthi_div_lat got=%0d exp=9", n); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL mthi_div_hi got=%h exp=2", hi); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL mthi_div_lo got=%h exp=e", lo); end
    endtask

    task automatic test_div_zero_and_nop;
        int n;
        run_op(OP_DIVU, 32'h12345678, 32'd0, n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divz_lat got=%0d exp=10", n); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divz_hi got=%h exp=2", hi); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divz_lo got=%h exp=e", lo); end
        run_op(4'd11, 32'd9, 32'd9, n);
        checks++; if (n !== 0) begin errors++; $display("FAIL undef_busy got=%0d exp=0", n); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL undef_hilo got=%h exp=2_e", {hi, lo}); end
    endtask

    task automatic test_back_to_back;
        int n;
        run_op(OP_MULTU, 32'd6, 32'd7, n);
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL b2b_first_lo got=%h exp=2a", lo); end
        run_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_lat got=%0d exp=5", n); end
        checks++; if ({hi, lo} !== 64'd1) begin errors++; $display("FAIL b2b_hilo got=%h exp=1", {hi, lo}); end
    endtask

    task automatic test_reset_mid_run;
        int n;
        issue(OP_MULT, 32'h10000, 32'h30000);
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy, hi, lo} !== 65'd0) begin errors++; $display("FAIL rst_mid got=%h exp=0", {busy, hi, lo}); end
        @(negedge clk); start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; op = OP_NOP;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_vs_start got=%b exp=0", busy); end
        @(negedge clk); reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if ({busy, hi, lo} !== 65'd0) begin errors++; $display("FAIL rst_abort got=%h exp=0", {busy, hi, lo}); end
        n = 0;
    endtask

    task automatic test_madd;
        int n;
        issue(OP_MTLO, 32'd5, 32'd0);
        issue(OP_MTHI, 32'd0, 32'd0);
        run_op(OP_MADD, 32'd3, 32'd4, n);
`ifdef MDU_MADD_EN
        checks++; if (n !== 5) begin errors++; $display("FAIL madd_lat got=%0d exp=5", n); end
        checks++; if ({hi, lo} !== 64'd17) begin errors++; $display("FAIL madd_hilo got=%h exp=11", {hi, lo}); end
`else
        checks++; if (n !== 0) begin errors++; $display("FAIL madd_nop_busy got=%0d exp=0", n); end
        checks++; if ({hi, lo} !== 64'd5) begin errors++; $display("FAIL madd_nop_hilo got=%h exp=5", {hi, lo}); end
`endif
        run_op(OP_MSUB, 32'd2, 32'd10, n);
`ifdef MDU_MADD_EN
        checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL msub_hilo got=%h exp=fffffffffffffffd", {hi, lo}); end
`else
        checks++; if ({hi, lo} !== 64'd5) begin errors++; $display("FAIL msub_nop_hilo got=%h exp=5", {hi, lo}); end
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = OP_NOP; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); reset = 1'b0;
        test_mult();
        test_div();
        test_mtlo();
        test_mthi_during_div();
        test_div_zero_and_nop();
        test_back_to_back();
        test_reset_mid_run();
        test_madd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
